conv3x3_filter: RTL

//   Parametrised 3x3 convolution stage for the edge-detection pipeline: one kernel, loaded at run time, that replaces the fixed Gaussian blur.

---
 rtl/conv3x3_filter_if.sv | 29 ++
 rtl/conv3x3_filter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/conv3x3_filter_if.sv
// Handshake and configuration bundle for conv3x3_filter.
// slave is the filter's view; master is the view of whoever drives it.
interface conv3x3_filter_if #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
);
  logic                 i_valid;
  logic                 i_ready;
  logic [9*PIX_W-1:0]   i_data;
  logic                 o_valid;
  logic                 o_ready;
  logic [PIX_W-1:0]     o_data;
  logic                 cfg_we;
  logic [3:0]           cfg_addr;
  logic [COEF_W-1:0]    cfg_wdata;
  logic                 cfg_commit;

  // valid/ready: a transfer happens on a rising edge where valid && ready;
  // the sender holds data stable while valid is high and ready is low.
  modport slave (
    input  i_valid, i_data, o_ready, cfg_we, cfg_addr, cfg_wdata, cfg_commit,
    output i_ready, o_valid, o_data
  );

  modport master (
    output i_valid, i_data, o_ready, cfg_we, cfg_addr, cfg_wdata, cfg_commit,
    input  i_ready, o_valid, o_data
  );
endinterface

// File: rtl/conv3x3_filter.sv
// Run-time programmable 3x3 convolution: multiply, sum, normalise in three
// registered stages, with a shadow/active coefficient bank pair.
module conv3x3_filter #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
) (
  input  logic           CLK,
  input  logic           RST,
  conv3x3_filter_if.slave bus
);

  localparam int ACC_W  = PIX_W + COEF_W + 5;
  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam logic        [ACC_W:0] PIX_MAX_U = (ACC_W+1)'((1 << PIX_W) - 1);
  localparam logic signed [ACC_W:0] PIX_MAX_S = $signed(PIX_MAX_U);

  typedef logic signed [COEF_W-1:0] coef_t;

  function automatic coef_t gauss_coef(input int k);
    case (k)
      4:          return coef_t'(4);
      1, 3, 5, 7: return coef_t'(2);
      default:    return coef_t'(1);
    endcase
  endfunction

  coef_t       sh_coef_q [9];
  coef_t       sh_coef_d [9];
  coef_t       act_coef_q[9];
  logic [3:0]  sh_shift_q, sh_shift_d, act_shift_q;
  logic [1:0]  sh_mode_q, sh_mode_d, act_mode_q;

  logic                     en;
  logic signed [PROD_W-1:0] prod_d   [9];
  logic signed [PROD_W-1:0] s1_prod_q[9];
  logic                     s1_valid_q, s2_valid_q, o_valid_q;
  logic [3:0]               s1_shift_q, s2_shift_q;
  logic [1:0]               s1_mode_q, s2_mode_q;
  logic [PIX_W-1:0]         s1_ctr_q, s2_ctr_q, o_data_q, norm_d;
  logic signed [ACC_W-1:0]  sum_d, s2_sum_q;
  logic signed [ACC_W:0]    sum_x, rnd_x, r_x, q_x, mag_x;
  logic        [ACC_W:0]    mq_x;

  // A write folds into the next shadow value first, so a same-cycle commit
  // copies the freshly written entry.
  always_comb begin
    sh_coef_d  = sh_coef_q;
    sh_shift_d = sh_shift_q;
    sh_mode_d  = sh_mode_q;
    if (bus.cfg_we) begin
      for (int k = 0; k < 9; k++) begin
        if (bus.cfg_addr == 4'(k)) sh_coef_d[k] = bus.cfg_wdata;
      end
      if (bus.cfg_addr == 4'd9) begin
        sh_shift_d = bus.cfg_wdata[3:0];
        sh_mode_d  = bus.cfg_wdata[5:4];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 9; k++) begin
        sh_coef_q[k]  <= gauss_coef(k);
        act_coef_q[k] <= gauss_coef(k);
      end
      sh_shift_q  <= 4'd4;
      act_shift_q <= 4'd4;
      sh_mode_q   <= 2'b00;
      act_mode_q  <= 2'b00;
    end else begin
      sh_coef_q  <= sh_coef_d;
      sh_shift_q <= sh_shift_d;
      sh_mode_q  <= sh_mode_d;
      if (bus.cfg_commit) begin
        act_coef_q  <= sh_coef_d;
        act_shift_q <= sh_shift_d;
        act_mode_q  <= sh_mode_d;
      end
    end
  end

  assign en          = !o_valid_q || bus.o_ready;
  assign bus.i_ready = en && !RST;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;

  // Taps are zero-extended to signed before multiplying by the signed coefficient.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_d[k] = PROD_W'(act_coef_q[k]) *
                  PROD_W'($signed({1'b0, bus.i_data[k*PIX_W +: PIX_W]}));
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < 9; k++) begin
      sum_d = sum_d + ACC_W'(s1_prod_q[k]);
    end
  end

  // Round half up by adding half an LSB of the shifted result before shifting.
  always_comb begin
    sum_x  = (ACC_W+1)'(s2_sum_q);
    rnd_x  = (s2_shift_q == 4'd0) ? '0 : ((ACC_W+1)'(1) << (s2_shift_q - 4'd1));
    r_x    = sum_x + rnd_x;
    q_x    = r_x >>> s2_shift_q;
    mag_x  = sum_x[ACC_W] ? -sum_x : sum_x;
    mq_x   = (mag_x + rnd_x) >> s2_shift_q;
    norm_d = '0;
    case (s2_mode_q)
      2'b10: norm_d = s2_ctr_q;
      2'b01: norm_d = (mq_x > PIX_MAX_U) ? {PIX_W{1'b1}} : mq_x[PIX_W-1:0];
      default: begin
        if (q_x[ACC_W])           norm_d = '0;
        else if (q_x > PIX_MAX_S) norm_d = {PIX_W{1'b1}};
        else                      norm_d = q_x[PIX_W-1:0];
      end
    endcase
  end

  // Shift and mode ride along with each window so later commits cannot touch it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
    end else if (en) begin
      s1_valid_q <= bus.i_valid;
      s1_prod_q  <= prod_d;
      s1_shift_q <= act_shift_q;
      s1_mode_q  <= act_mode_q;
      s1_ctr_q   <= bus.i_data[4*PIX_W +: PIX_W];
      s2_valid_q <= s1_valid_q;
      s2_sum_q   <= sum_d;
      s2_shift_q <= s1_shift_q;
      s2_mode_q  <= s1_mode_q;
      s2_ctr_q   <= s1_ctr_q;
      o_valid_q  <= s2_valid_q;
      if (s2_valid_q) o_data_q <= norm_d;
    end
  end

endmodule
